// File: rtl/pipe_adder_pkg.sv
// Shared types, defaults and configuration helpers for the segmented pipelined adder.
package pipe_adder_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SEG_DEF   = 2;
    localparam int SEG_W     = WIDTH_DEF / SEG_DEF;
    localparam int LATENCY   = SEG_DEF;

    // Per-operation control that travels alongside the data through every stage.
    typedef struct packed {
        logic valid;
        logic sub;
        logic signed_mode;
    } stage_ctrl_t;

    // Width of one carry segment.
    function automatic int seg_width(input int width, input int seg);
        return width / seg;
    endfunction

    // Legal configuration: 1..8 segments that evenly divide the operand width.
    function automatic bit cfg_ok(input int width, input int seg);
        return (seg >= 1) && (seg <= 8) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_seg_stage.sv
// One carry segment: SW-bit adder for segment K plus the stage register that carries
// the skewed operands, the deskewed partial sum, the segment carry and the control.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 16,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             cin_i,
    input  stage_ctrl_t      ctrl_i,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output stage_ctrl_t      ctrl_q
);

    logic [SW:0]      seg_sum;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] s_d;
    logic             c_d;
    stage_ctrl_t      ctrl_d;

    // Add this stage's operand slice with the incoming carry.
    always_comb begin
        seg_sum = {1'b0, a_i[K*SW +: SW]} + {1'b0, b_i[K*SW +: SW]} + {{SW{1'b0}}, cin_i};
    end

    // Next state: clear beats enable; a stalled stage holds everything.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        c_d    = c_q;
        ctrl_d = ctrl_q;
        if (clear) begin
            a_d    = '0;
            b_d    = '0;
            s_d    = '0;
            c_d    = 1'b0;
            ctrl_d = '0;
        end else if (enable) begin
            a_d               = a_i;
            b_d               = b_i;
            s_d               = s_i;
            s_d[K*SW +: SW]   = seg_sum[SW-1:0];
            c_d               = seg_sum[SW];
            ctrl_d            = ctrl_i;
        end
    end

    // Stage register; the reset input is active-high and asynchronous.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= 1'b0;
            ctrl_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            ctrl_q <= ctrl_d;
        end
    end

endmodule

// File: rtl/pipe_adder_seg.sv
// Pipelined adder/subtractor: the carry chain is cut into SEG segments, one register
// stage each. Operands skew forward, partial sums deskew forward, and the final stage
// drives qualified outputs and the mode-dependent overflow flag.
module pipe_adder_seg
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG   = SEG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             in_valid,
    input  logic             sub,
    input  logic             signed_mode,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SW   = seg_width(WIDTH, SEG);
    localparam int LAST = SEG - 1;

    if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_check
        $error("pipe_adder_seg: SEG must be 1..8 and divide WIDTH");
    end

    // Stage k register outputs: skewed operands, deskewed sum, segment carry, control.
    logic [WIDTH-1:0] a_skew_q     [SEG];
    logic [WIDTH-1:0] b_skew_q     [SEG];
    logic [WIDTH-1:0] sum_deskew_q [SEG];
    logic             carry_q      [SEG];
    stage_ctrl_t      ctrl_q       [SEG];

    logic [WIDTH-1:0] b_in;
    stage_ctrl_t      ctrl_in;

    // Subtraction is A + ~B + 1: invert B here, the +1 is stage 0's carry-in.
    always_comb begin
        b_in                = in2 ^ {WIDTH{sub}};
        ctrl_in.valid       = in_valid;
        ctrl_in.sub         = sub;
        ctrl_in.signed_mode = signed_mode;
    end

    for (genvar k = 0; k < SEG; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_adder_stage #(.WIDTH(WIDTH), .SW(SW), .K(0)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .enable (enable),
                .clear  (clear),
                .a_i    (in1),
                .b_i    (b_in),
                .s_i    ({WIDTH{1'b0}}),
                .cin_i  (sub),
                .ctrl_i (ctrl_in),
                .a_q    (a_skew_q[0]),
                .b_q    (b_skew_q[0]),
                .s_q    (sum_deskew_q[0]),
                .c_q    (carry_q[0]),
                .ctrl_q (ctrl_q[0])
            );
        end else begin : g_next
            pipe_adder_stage #(.WIDTH(WIDTH), .SW(SW), .K(k)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .enable (enable),
                .clear  (clear),
                .a_i    (a_skew_q[k-1]),
                .b_i    (b_skew_q[k-1]),
                .s_i    (sum_deskew_q[k-1]),
                .cin_i  (carry_q[k-1]),
                .ctrl_i (ctrl_q[k-1]),
                .a_q    (a_skew_q[k]),
                .b_q    (b_skew_q[k]),
                .s_q    (sum_deskew_q[k]),
                .c_q    (carry_q[k]),
                .ctrl_q (ctrl_q[k])
            );
        end
    end

    // Only the MSBs of the last stage's skewed operands feed the overflow logic.
    logic unused_skew;
    assign unused_skew = ^{a_skew_q[LAST], b_skew_q[LAST]};

    stage_ctrl_t ctrl_last;
    logic        c_msb;
    logic        c_into_msb;
    logic        ovf_raw;

    // Overflow from the registered last stage; outputs are forced to 0 when not valid.
    always_comb begin
        ctrl_last  = ctrl_q[LAST];
        c_msb      = carry_q[LAST];
        c_into_msb = a_skew_q[LAST][WIDTH-1] ^ b_skew_q[LAST][WIDTH-1]
                   ^ sum_deskew_q[LAST][WIDTH-1];
        if (ctrl_last.signed_mode) begin
            ovf_raw = c_into_msb ^ c_msb;
        end else if (ctrl_last.sub) begin
            ovf_raw = ~c_msb;
        end else begin
            ovf_raw = c_msb;
        end
        out_valid = ctrl_last.valid;
        out       = ctrl_last.valid ? sum_deskew_q[LAST] : '0;
        carry_out = ctrl_last.valid & c_msb;
        overflow  = ctrl_last.valid & ovf_raw;
    end

endmodule

// File: doc/pipe_adder_seg.md
# pipe_adder_seg

Parametrised, pipelined two's-complement adder/subtractor for the E203 self-test datapath. The carry chain is split into `SEG` equal segments, with one register stage per segment, giving full throughput at `SEG` cycles of latency. Each operation carries its own valid, sign mode and add/sub mode through the pipeline. The block supports a global stall, a synchronous flush and mode-correct overflow detection. It supersedes the fixed 32-bit two-stage adder in the same hierarchy.

## Interface
- `WIDTH`, default 32: operand and result width. Must be divisible by `SEG`.
- `SEG`, default 2: number of carry segments, which equals the number of pipeline stages. Legal range 1..8.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-high. All state clears while it is asserted.
- `in1`, input, `WIDTH`: operand A.
- `in2`, input, `WIDTH`: operand B.
- `in_valid`, input, 1: operands and modes are valid this cycle.
- `sub`, input, 1: 1 computes A−B; 0 computes A+B.
- `signed_mode`, input, 1: 1 selects the signed overflow rule; 0 selects the unsigned rule.
- `enable`, input, 1: pipeline advance. 0 freezes every register.
- `clear`, input, 1: synchronous flush of all stages.
- `out`, output, `WIDTH`: result, A±B mod 2^`WIDTH`.
- `out_valid`, output, 1: `out`, `carry_out` and `overflow` are valid.
- `carry_out`, output, 1: raw carry out of the MSB. For `sub`, 1 means no borrow.
- `overflow`, output, 1: result is not representable in the selected mode.

## Operation
- Segment width is `SW` = `WIDTH`/`SEG`. Stage k (0..`SEG`−1) adds bits [k·SW +: SW] plus carry-in and produces SW sum bits and a carry out.
- Stage 0 carry-in is `sub`. B is bitwise inverted when `sub`=1.
- Operand segments above stage k are carried forward in skew registers until their own stage.
- Sum segments already computed are carried forward in deskew registers until the final stage.
- `valid`, `sub` and `signed_mode` travel with the data through every stage.
- Overflow rules, evaluated at the final stage:
  - Unsigned add: `overflow` = c_msb.
  - Unsigned sub: `overflow` = ~c_msb (borrow).
  - Signed, either op: `overflow` = c_into_msb ^ c_msb.
- Priority per cycle: reset, then `clear`, then `enable`.
- `clear`=1 zeroes every stage register and every valid bit at the next edge, regardless of `enable`.
- `enable`=0 with `clear`=0: all registers hold, including the output registers and `out_valid`.
- `in_valid`=0 with `enable`=1: a bubble enters. Data registers may update (don't care), but the valid bit is 0.
- When `out_valid`=0, the outputs are driven to 0 (qualified), not left as stale data.
- `SEG`=1 degenerates to a single registered full-width adder with 1-cycle latency.

## Timing
- Reset value of every output is 0: `out`, `out_valid`, `carry_out`, `overflow`. Reset takes effect asynchronously, mid-operation included. In-flight operations are discarded, not completed.
- Latency is exactly `SEG` enabled cycles from the `in_valid` edge to `out_valid`=1. With default parameters an input at edge n appears after edge n+2.
- Throughput is one operation per enabled cycle. Back-to-back inputs produce back-to-back outputs in order.
- Stall cycles (`enable`=0) add latency 1:1. No operation is lost or duplicated.
- `clear` and `in_valid` asserted together: the incoming operation is dropped as well.
- After `clear`, the first result can appear `SEG` cycles after the next valid input.
- There is no combinational path from any input to any output. All outputs are registered.

## Structure
- A shared package `pipe_adder_pkg` holds:
  - `SEG_W` (`WIDTH`/`SEG`) and `LATENCY` (=`SEG`) as derived localparams.
  - A stage-control struct {valid, sub, signed_mode}.
  - A compile-time check that `WIDTH` % `SEG` == 0.
- Sub-module `pipe_adder_stage`: one SW-bit adder with carry-in/out and its stage register. It is instantiated `SEG` times in a generate loop.
- The top level holds the skew and deskew arrays and the final overflow logic.

## Test plan
- Unsigned add, `WIDTH`=32, `SEG`=2: 0xFFFF_FFFF + 0x1 → after 2 cycles `out`=0, `carry_out`=1, `overflow`=1.
- Signed add: 0x7FFF_FFFF + 0x1 with `signed_mode`=1 → `out`=0x8000_0000, `carry_out`=0, `overflow`=1. 0xFFFF_FFFF + 0x1 → `out`=0, `overflow`=0.
- Subtract: 5 − 7 with `sub`=1 → `out`=0xFFFF_FFFE, `carry_out`=0. Unsigned gives `overflow`=1; signed gives `overflow`=0.
- Streaming with stall: 4 back-to-back ops (1+1, 2+2, 0x0000_FFFF+1, 0x8000_0000+0x8000_0000), with `enable` low for 3 cycles mid-stream → results 2, 4, 0x0001_0000, 0 in order. `out_valid` is held during the stall.
- Flush and reset: `clear` asserted with 2 ops in flight → `out_valid` never rises for them. Asynchronous `rst_n` pulse mid-stream → all outputs 0 immediately, without waiting for a clock edge.
- Parameter sweep with `WIDTH`=64 and `SEG` in {1, 4, 8}: random operands against a reference model; latency equals `SEG` in every case.
